// File: rtl/mux_n_arb.sv
// N-input valid/ready arbiter-mux with a registered output stage.
// Round-robin or fixed-priority grant, plus a force-select override.
module mux_n_arb #(
  parameter int DATA_W    = 16,
  parameter int N_IN      = 3,
  parameter int SEL_W     = $clog2(N_IN),
  parameter int PRIO_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [N_IN-1:0]        in_valid,
  output logic [N_IN-1:0]        in_ready,
  input  logic                   force_en,
  input  logic [SEL_W-1:0]       force_sel,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SEL_W-1:0]       out_sel
);

  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  gnt;
  logic              gnt_vld;
  logic              load_en;
  logic              xfer;
  logic [DATA_W-1:0] gnt_data;
  int                idx;

  assign load_en = !out_valid || out_ready;

  always_comb begin : arb
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    if (force_en) begin
      // out-of-range force_sel matches no i, so it never aliases
      for (int i = 0; i < N_IN; i++) begin
        if (force_sel == SEL_W'(i) && in_valid[i]) begin
          gnt     = SEL_W'(i);
          gnt_vld = 1'b1;
        end
      end
    end else if (PRIO_MODE == 1) begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          gnt     = SEL_W'(i);
          gnt_vld = 1'b1;
        end
      end
    end else begin
      // scan farthest-first so the nearest successor of rr_ptr wins
      for (int k = N_IN; k >= 1; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_IN) idx = idx - N_IN;
        if (in_valid[idx]) begin
          gnt     = SEL_W'(idx);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  assign xfer     = rst_n && gnt_vld && load_en;
  assign gnt_data = in_data[int'(gnt)*DATA_W +: DATA_W];

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= SEL_W'(N_IN - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_sel   <= gnt;
      if (!force_en && PRIO_MODE == 0) rr_ptr <= gnt;
    end else if (load_en) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_arb.sv
// Directed bench for mux_n_arb: round-robin and fixed-priority
// instances share stimulus; beats are checked through a scoreboard.
module tb_mux_n_arb;

  localparam int DW = 16;
  localparam int N  = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic          force_en;
  logic [SW-1:0] force_sel;
  logic          out_ready;

  logic [N-1:0]  rdy_rr, rdy_fp;
  logic [DW-1:0] od_rr, od_fp;
  logic          ov_rr, ov_fp;
  logic [SW-1:0] os_rr, os_fp;

  logic [DW-1:0] dat [N];

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
  } beat_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;

  assign in_data = {dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  mux_n_arb #(.DATA_W(DW), .N_IN(N), .PRIO_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_rr),
    .force_en(force_en), .force_sel(force_sel),
    .out_data(od_rr), .out_valid(ov_rr),
    .out_ready(out_ready), .out_sel(os_rr)
  );

  mux_n_arb #(.DATA_W(DW), .N_IN(N), .PRIO_MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_fp),
    .force_en(force_en), .force_sel(force_sel),
    .out_data(od_fp), .out_valid(ov_fp),
    .out_ready(out_ready), .out_sel(os_fp)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // er: expected in_ready of the RR instance; eov: out_valid after edge
  task automatic step(input string tag,
                      input logic [N-1:0] er,
                      input logic eov);
    beat_t b;
    #1;
    chk({tag, ".rdy"}, 32'(rdy_rr), 32'(er));
    for (int i = 0; i < N; i++) begin
      if (er[i]) begin
        b.sel  = SW'(i);
        b.data = dat[i];
        sb.push_back(b);
      end
    end
    tick;
    chk({tag, ".ov"}, 32'(ov_rr), 32'(eov));
    if (sb.size() > 0) begin
      b = sb.pop_front();
      chk({tag, ".sel"}, 32'(os_rr), 32'(b.sel));
      chk({tag, ".data"}, 32'(od_rr), 32'(b.data));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 3'b111;
    out_ready = 1'b1;
    force_en  = 1'b0;
    force_sel = '0;
    dat[0]    = 16'h000A;
    dat[1]    = 16'h000B;
    dat[2]    = 16'h000C;

    // reset held two cycles with all inputs valid
    #1;
    chk("rst0.rdy", 32'(rdy_rr), 32'h0);
    for (int c = 0; c < 2; c++) begin
      tick;
      chk("rst.ov", 32'(ov_rr), 32'h0);
      chk("rst.data", 32'(od_rr), 32'h0);
      chk("rst.sel", 32'(os_rr), 32'h0);
      chk("rst.rdy", 32'(rdy_rr), 32'h0);
    end
    rst_n = 1'b1;

    // round-robin, full throughput
    step("rr0", 3'b001, 1'b1);
    step("rr1", 3'b010, 1'b1);
    step("rr2", 3'b100, 1'b1);
    step("rr3", 3'b001, 1'b1);
    step("rr4", 3'b010, 1'b1);
    step("rr5", 3'b100, 1'b1);

    // backpressure
    dat[1]   = 16'h1234;
    in_valid = 3'b010;
    step("bp_load", 3'b010, 1'b1);
    out_ready = 1'b0;
    in_valid  = 3'b101;
    for (int c = 0; c < 3; c++) begin
      step("bp_hold", 3'b000, 1'b1);
      chk("bp_hold.data", 32'(od_rr), 32'h1234);
      chk("bp_hold.sel", 32'(os_rr), 32'h1);
    end
    out_ready = 1'b1;
    step("bp_drain", 3'b100, 1'b1);
    dat[1]   = 16'h000B;
    in_valid = 3'b111;
    step("pre_force", 3'b001, 1'b1);

    // force override leaves rr_ptr at 0
    force_en  = 1'b1;
    force_sel = 2'd2;
    step("frc0", 3'b100, 1'b1);
    step("frc1", 3'b100, 1'b1);
    step("frc2", 3'b100, 1'b1);
    force_en = 1'b0;
    step("frc_resume", 3'b010, 1'b1);
    force_en  = 1'b1;
    force_sel = 2'd3;
    step("frc_oob", 3'b000, 1'b0);
    force_en = 1'b0;

    // fixed priority instance
    in_valid = 3'b110;
    #1;
    chk("fp0.rdy", 32'(rdy_fp), 32'b010);
    tick;
    chk("fp0.sel", 32'(os_fp), 32'h1);
    chk("fp0.data", 32'(od_fp), 32'h000B);
    in_valid = 3'b111;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("fp1.rdy", 32'(rdy_fp), 32'b001);
      tick;
      chk("fp1.ov", 32'(ov_fp), 32'h1);
      chk("fp1.sel", 32'(os_fp), 32'h0);
      chk("fp1.data", 32'(od_fp), 32'h000A);
    end

    // reset while a beat is stalled in the output stage
    dat[0]   = 16'hBEEF;
    in_valid = 3'b001;
    step("mrs_load", 3'b001, 1'b1);
    out_ready = 1'b0;
    in_valid  = 3'b111;
    tick;
    chk("mrs_hold.data", 32'(od_rr), 32'hBEEF);
    chk("mrs_hold.ov", 32'(ov_rr), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mrs.rdy", 32'(rdy_rr), 32'h0);
    tick;
    chk("mrs.ov", 32'(ov_rr), 32'h0);
    chk("mrs.data", 32'(od_rr), 32'h0);
    chk("mrs.sel", 32'(os_rr), 32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step("mrs_first", 3'b001, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_n_arb.md
Name: mux_n_arb

Overview:
- Parametrised N-input successor to the fixed 3-way datapath mux.
- Selects one of N_IN valid/ready input channels and registers the winner into a single output stage, one beat per cycle.
- Arbitration is either round-robin or fixed-priority. A force-select override reproduces plain mux steering.
- Used wherever several producers share one consumer, for example writeback or forwarding sources into a pipeline register.

Parameters:
- DATA_W, 16: width of each data channel.
- N_IN, 3: number of input channels, 2..16.
- SEL_W, $clog2(N_IN): width of the select and index fields.
- PRIO_MODE, 0: 0 = round-robin, 1 = fixed priority with the lowest index winning.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous active-low reset.
- in_data, input, N_IN*DATA_W: packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid, input, N_IN: per-channel valid.
- in_ready, output, N_IN: per-channel ready; combinational; one-hot or zero.
- force_en, input, 1: when 1, bypasses arbitration.
- force_sel, input, SEL_W: channel to use when force_en=1.
- out_data, output, DATA_W: registered selected data.
- out_valid, output, 1: registered; output stage holds a beat.
- out_ready, input, 1: downstream accepts the beat.
- out_sel, output, SEL_W: registered index of the channel that produced out_data.

Behaviour:
- Reset: applied only at a clk edge with rst_n=0 (no asynchronous path).
  - Resets out_valid=0, out_data=0, out_sel=0, and rr_ptr (last-granted index) = N_IN-1.
  - in_ready is forced to all 0 while rst_n=0.
  - A beat held in the output stage when reset is applied is dropped.
- load_en = !out_valid || out_ready. The output stage can load this cycle.
- Grant, combinational:
  - force_en=1:
    - grant = force_sel, provided force_sel < N_IN and in_valid[force_sel]=1. Otherwise there is no grant.
    - Other channels are never granted in that cycle.
  - force_en=0, PRIO_MODE=1: grant = lowest i with in_valid[i]=1.
  - force_en=0, PRIO_MODE=0:
    - Search order is rr_ptr+1, rr_ptr+2, ..., wrapping modulo N_IN; the first valid channel wins.
    - rr_ptr itself is checked last.
- in_ready[g] = load_en for the granted channel g; all other in_ready bits = 0. No valid means no grant and in_ready=0.
- Transfer happens when in_valid[g] && in_ready[g]. On the next edge:
  - out_data <= channel g data.
  - out_sel <= g.
  - out_valid <= 1.
  - rr_ptr <= g, only when force_en=0 and PRIO_MODE=0; forced and fixed-priority grants leave rr_ptr unchanged.
- If load_en=1 and there is no transfer, the next edge sets out_valid <= 0. out_data and out_sel hold their previous values.
- If load_en=0 (out_valid=1 and out_ready=0), out_data, out_sel and out_valid hold stable.
- Latency and throughput: one cycle from input handshake to out_valid. Full throughput (1 beat/cycle) while out_ready=1.
- Simultaneous events: an output drain and a new input transfer in the same cycle is legal; the stage reloads with no bubble.
- Fairness (PRIO_MODE=0): with all channels continuously valid, grants cycle 0,1,...,N_IN-1,0,... Each channel waits at most N_IN-1 beats between its own grants.
- Width rules:
  - Arithmetic on rr_ptr wraps modulo N_IN, not modulo 2^SEL_W. This matters for non-power-of-two N_IN.
  - force_sel values >= N_IN grant nothing. They must not alias onto a channel.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 for 2 cycles with all in_valid=1.
  - Required: out_valid=0, out_data=0, out_sel=0, in_ready=000 throughout.
  - First cycle after release (PRIO_MODE=0, N_IN=3): in_ready=001.
- Round-robin:
  - Stimulus: N_IN=3, data ch0=0x000A, ch1=0x000B, ch2=0x000C, all valid, out_ready=1 for 6 cycles.
  - Required: out_sel sequence 0,1,2,0,1,2 with matching out_data; out_valid=1 every cycle from cycle 1.
- Backpressure:
  - Stimulus: one beat 0x1234 accepted from ch1, then out_ready=0 for 3 cycles with ch0 and ch2 valid.
  - Required: out_data=0x1234 and out_sel=1 stay stable; in_ready=000.
  - Then out_ready=1: the same cycle drains and reloads from ch2 (next after rr_ptr=1) with no bubble.
- Force override:
  - Stimulus: force_en=1, force_sel=2, all valid.
  - Required: only in_ready[2]=1; out_sel=2 every beat; rr_ptr unchanged. Clearing force_en resumes RR from the pre-force pointer.
  - Stimulus: force_sel=3 with N_IN=3. Required: in_ready=000; out_valid drops to 0.
- Fixed priority:
  - Stimulus: PRIO_MODE=1, valid 110 then 111.
  - Required: grants ch1, then ch0; ch2 starves while ch0/ch1 are valid.
- Reset mid-operation:
  - Stimulus: out_valid=1 holding 0xBEEF with out_ready=0; pulse rst_n=0 for one cycle.
  - Required: out_valid=0 and out_data=0 at the next edge; rr_ptr restarts so ch0 wins first.
